// File: rtl/mem_pkg.sv
// Shared types and constants for the clocked word memory controller and its byte banks.
package mem_pkg;

  localparam int BYTE_W = 8;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_byte_bank.sv
// One byte lane of word storage: synchronous write port and a read register
// that only loads when the controller signals a read commit.
module mem_byte_bank
  import mem_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A,
  input  logic              WE,
  input  logic              RE,
  input  logic [BYTE_W-1:0] DIN,
  output logic [BYTE_W-1:0] DOUT
);

  logic [BYTE_W-1:0] mem_q [2**ADDR_W];
  logic [BYTE_W-1:0] dout_q;

  // Storage is never reset; its contents survive RST.
  always_ff @(posedge CLK) begin
    if (WE) begin
      mem_q[A] <= DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q <= '0;
    end else if (RE) begin
      dout_q <= mem_q[A];
    end
  end

  assign DOUT = dout_q;

endmodule

// File: rtl/mem_word_ctrl.sv
// Request/acknowledge word memory controller: latches a request, waits
// WAIT_CYCLES access cycles, commits to the byte banks, then pulses ACK.
module mem_word_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int LANES       = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      REQ,
  input  logic                      WR,
  input  logic [ADDR_W-1:0]         A,
  input  logic [LANES-1:0]          BE,
  input  logic [BYTE_W*LANES-1:0]   D_WRITE,
  output logic [BYTE_W*LANES-1:0]   D_READ,
  output logic                      ACK,
  output logic                      BUSY
);

  localparam int DW = BYTE_W * LANES;

  mem_state_t        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LANES-1:0]  be_q;
  logic [DW-1:0]     din_q;
  logic              commit;
  logic              capture;
  logic [LANES-1:0]  bankWe;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ) state_d = SETUP;
      end
      SETUP: begin
        cnt_d = WAIT_W'(WAIT_CYCLES);
        if (WAIT_CYCLES == 0) begin
          commit  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == WAIT_W'(1)) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are captured only on the accept edge; later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      be_q   <= '0;
      din_q  <= '0;
    end else if (state_q == IDLE && REQ) begin
      wr_q   <= WR;
      addr_q <= A;
      be_q   <= BE;
      din_q  <= D_WRITE;
    end
  end

  // A reset on the commit edge suppresses both the bank write and the read capture.
  assign capture = commit & ~wr_q & ~RST;
  assign bankWe  = {LANES{commit & wr_q & ~RST}} & be_q;
  assign ACK     = (state_q == DONE);
  assign BUSY    = (state_q != IDLE);

  for (genvar g = 0; g < LANES; g++) begin : gLane
    mem_byte_bank #(
      .ADDR_W(ADDR_W)
    ) uBank (
      .CLK  (CLK),
      .RST  (RST),
      .A    (addr_q),
      .WE   (bankWe[g]),
      .RE   (capture),
      .DIN  (din_q[g*BYTE_W +: BYTE_W]),
      .DOUT (D_READ[g*BYTE_W +: BYTE_W])
    );
  end

endmodule

// File: tb/tb_mem_word_ctrl.sv
// Bench for mem_word_ctrl: four instances (WAIT 1, WAIT 0, WAIT 3, 2-lane/16-word)
// checked against a byte-addressed memory model and cycle-exact handshake timing.
module tb_mem_word_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst [4];
  logic        req [4];
  logic        wr  [4];
  logic [14:0] a   [4];
  logic [3:0]  be  [4];
  logic [31:0] dw  [4];

  wire [31:0] dr0, dr1, dr2;
  wire [15:0] dr3;
  wire        ack0, ack1, ack2, ack3;
  wire        busy0, busy1, busy2, busy3;

  int tot = 0;
  int bad = 0;

  logic [7:0]  mdl [int];
  logic [31:0] lastRd [4];
  logic [14:0] pool0 [8];
  logic [14:0] pool1 [4];

  mem_word_ctrl #(.ADDR_W(15), .LANES(4), .WAIT_CYCLES(1)) u0 (
    .CLK(CLK), .RST(rst[0]), .REQ(req[0]), .WR(wr[0]), .A(a[0]), .BE(be[0]),
    .D_WRITE(dw[0]), .D_READ(dr0), .ACK(ack0), .BUSY(busy0));
  mem_word_ctrl #(.ADDR_W(15), .LANES(4), .WAIT_CYCLES(0)) u1 (
    .CLK(CLK), .RST(rst[1]), .REQ(req[1]), .WR(wr[1]), .A(a[1]), .BE(be[1]),
    .D_WRITE(dw[1]), .D_READ(dr1), .ACK(ack1), .BUSY(busy1));
  mem_word_ctrl #(.ADDR_W(15), .LANES(4), .WAIT_CYCLES(3)) u2 (
    .CLK(CLK), .RST(rst[2]), .REQ(req[2]), .WR(wr[2]), .A(a[2]), .BE(be[2]),
    .D_WRITE(dw[2]), .D_READ(dr2), .ACK(ack2), .BUSY(busy2));
  mem_word_ctrl #(.ADDR_W(4), .LANES(2), .WAIT_CYCLES(1)) u3 (
    .CLK(CLK), .RST(rst[3]), .REQ(req[3]), .WR(wr[3]), .A(a[3][3:0]), .BE(be[3][1:0]),
    .D_WRITE(dw[3][15:0]), .D_READ(dr3), .ACK(ack3), .BUSY(busy3));

  function automatic int waitOf(int s);
    case (s)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int lanesOf(int s);
    return (s == 3) ? 2 : 4;
  endfunction

  function automatic logic [31:0] getDr(int s);
    case (s)
      0: return dr0;
      1: return dr1;
      2: return dr2;
      default: return {16'h0, dr3};
    endcase
  endfunction

  function automatic logic getAck(int s);
    case (s)
      0: return ack0;
      1: return ack1;
      2: return ack2;
      default: return ack3;
    endcase
  endfunction

  function automatic logic getBusy(int s);
    case (s)
      0: return busy0;
      1: return busy1;
      2: return busy2;
      default: return busy3;
    endcase
  endfunction

  function automatic int keyOf(int s, logic [14:0] addr, int lane);
    logic [14:0] ma;
    ma = (s == 3) ? (addr & 15'h000F) : addr;
    return (s << 20) | (int'(ma) << 2) | lane;
  endfunction

  function automatic logic [31:0] modelRead(int s, logic [14:0] addr);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < lanesOf(s); i++) begin
      r[8*i +: 8] = mdl.exists(keyOf(s, addr, i)) ? mdl[keyOf(s, addr, i)] : 8'hxx;
    end
    return r;
  endfunction

  task automatic modelWrite(input int s, input logic [14:0] addr, input logic [3:0] b,
                            input logic [31:0] d);
    for (int i = 0; i < lanesOf(s); i++) begin
      if (b[i]) mdl[keyOf(s, addr, i)] = d[8*i +: 8];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request, passes the accept edge and leaves the bench at the SETUP-cycle negedge.
  task automatic applyStimulus(input int s, input logic w, input logic [14:0] addr,
                               input logic [3:0] b, input logic [31:0] d);
    @(negedge CLK);
    req[s] = 1'b1; wr[s] = w; a[s] = addr; be[s] = b; dw[s] = d;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput($sformatf("busy_setup_%0d", s), 32'(getBusy(s)), 32'd1);
    checkOutput($sformatf("ack_setup_%0d", s), 32'(getAck(s)), 32'd0);
    req[s] = 1'b0;
    wr[s]  = 1'($urandom);
    a[s]   = 15'($urandom);
    be[s]  = 4'($urandom);
    dw[s]  = $urandom;
  endtask

  task automatic doOp(input int s, input logic w, input logic [14:0] addr,
                      input logic [3:0] b, input logic [31:0] d);
    int wc;
    logic [31:0] exp;
    wc = waitOf(s);
    applyStimulus(s, w, addr, b, d);
    for (int k = 2; k <= 3 + wc; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("ack_s%0d_k%0d", s, k), 32'(getAck(s)), 32'(k == 2 + wc));
      checkOutput($sformatf("busy_s%0d_k%0d", s, k), 32'(getBusy(s)), 32'(k <= 2 + wc));
      if (k == 2 + wc) begin
        if (!w) begin
          exp = modelRead(s, addr);
          checkOutput($sformatf("rdata_s%0d_a%h", s, addr), getDr(s), exp);
          lastRd[s] = exp;
        end else begin
          checkOutput($sformatf("hold_s%0d", s), getDr(s), lastRd[s]);
        end
      end
    end
    if (w) modelWrite(s, addr, b, d);
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] prior;
    for (int s = 0; s < 4; s++) begin
      rst[s] = 1'b1; req[s] = 1'b0; wr[s] = 1'b0; a[s] = '0; be[s] = '0; dw[s] = '0;
      lastRd[s] = '0;
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    for (int s = 0; s < 4; s++) rst[s] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      checkOutput($sformatf("rst_ack_%0d", s), 32'(getAck(s)), 32'd0);
      checkOutput($sformatf("rst_busy_%0d", s), 32'(getBusy(s)), 32'd0);
      checkOutput($sformatf("rst_dread_%0d", s), getDr(s), 32'd0);
    end

    doOp(0, 1'b1, 15'h0010, 4'hF, 32'hDEADBEEF);
    doOp(0, 1'b0, 15'h0010, 4'h0, 32'h0);
    checkOutput("full_word", getDr(0), 32'hDEADBEEF);
    doOp(0, 1'b1, 15'h0010, 4'h0, 32'h12345678);
    doOp(0, 1'b0, 15'h0010, 4'h0, 32'h0);
    checkOutput("be_zero", getDr(0), 32'hDEADBEEF);

    doOp(0, 1'b1, 15'h7FFF, 4'hF, 32'h11223344);
    doOp(0, 1'b1, 15'h7FFF, 4'h5, 32'hAABBCCDD);
    doOp(0, 1'b0, 15'h7FFF, 4'h0, 32'h0);
    checkOutput("byte_merge", getDr(0), 32'h11BB33DD);

    for (int i = 0; i < 8; i++) begin
      pool0[i] = 15'($urandom);
      doOp(0, 1'b1, pool0[i], 4'hF, $urandom);
    end
    for (int i = 0; i < 30; i++) begin
      doOp(0, 1'($urandom), pool0[$urandom_range(0, 7)], 4'($urandom), $urandom);
    end

    for (int i = 0; i < 4; i++) begin
      pool1[i] = 15'($urandom);
      doOp(1, 1'b1, pool1[i], 4'hF, $urandom);
    end
    @(negedge CLK);
    req[1] = 1'b1; wr[1] = 1'b0; a[1] = pool1[0];
    @(posedge CLK);
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("b2b_ack_k%0d", k), 32'(ack1), 32'(k % 3 == 2));
      checkOutput($sformatf("b2b_busy_k%0d", k), 32'(busy1), 32'(k % 3 != 0));
      if (k % 3 == 2) begin
        exp = modelRead(1, pool1[(k - 2) / 3]);
        checkOutput($sformatf("b2b_rdata_k%0d", k), dr1, exp);
        lastRd[1] = exp;
      end
      if (k == 1 || k == 4 || k == 7) a[1] = pool1[(k - 1) / 3 + 1];
      if (k == 10) req[1] = 1'b0;
    end

    @(negedge CLK);
    rst[1] = 1'b1; req[1] = 1'b1;
    @(negedge CLK);
    rst[1] = 1'b0; req[1] = 1'b0;
    checkOutput("rst_prio_busy", 32'(busy1), 32'd0);
    checkOutput("rst_prio_dread", dr1, 32'd0);
    lastRd[1] = '0;
    @(negedge CLK);
    checkOutput("rst_prio_busy2", 32'(busy1), 32'd0);

    prior = $urandom;
    doOp(2, 1'b1, 15'h0001, 4'hF, prior);
    doOp(2, 1'b0, 15'h0001, 4'h0, 32'h0);
    applyStimulus(2, 1'b1, 15'h0001, 4'hF, 32'hCAFEF00D);
    @(negedge CLK);
    checkOutput("abort_busy_k2", 32'(busy2), 32'd1);
    @(negedge CLK);
    checkOutput("abort_ack_k3", 32'(ack2), 32'd0);
    rst[2] = 1'b1;
    @(negedge CLK);
    rst[2] = 1'b0;
    checkOutput("abort_busy", 32'(busy2), 32'd0);
    checkOutput("abort_dread", dr2, 32'd0);
    lastRd[2] = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("abort_noack_%0d", k), 32'(ack2), 32'd0);
    end
    doOp(2, 1'b0, 15'h0001, 4'h0, 32'h0);
    checkOutput("abort_keep", dr2, prior);

    for (int i = 0; i < 16; i++) doOp(3, 1'b1, 15'(i), 4'h3, {16'h0, 16'($urandom)});
    prior = modelRead(3, 15'h0005);
    doOp(3, 1'b1, 15'h0005, 4'h2, 32'h0000BEEF);
    doOp(3, 1'b0, 15'h0005, 4'h0, 32'h0);
    checkOutput("width_upper", {24'h0, dr3[15:8]}, 32'h000000BE);
    checkOutput("width_lower", {24'h0, dr3[7:0]}, {24'h0, prior[7:0]});
    for (int i = 0; i < 10; i++) begin
      doOp(3, 1'($urandom), 15'($urandom_range(0, 15)), 4'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
